ntt_butterfly_sched: RTL and testbench
======================================

NTT_BUTTERFLY_SCHED -- requirements
Module: ntt_butterfly_sched

Interface
REQ-001 SHALL have parameter LOGN, default 8, meaning log2 of the transform length; n = 2^LOGN points.
REQ-002 SHALL have parameter N, default 17, meaning coefficient width; used only by the shared package typedefs.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run a full transform.
REQ-006 SHALL have port inv_mode  input  1  selects an inverse transform; sampled with start.
REQ-007 SHALL have port busy  output  1  high from the first issue cycle through the last write cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last write.
REQ-009 SHALL have port issue_valid  output  1  the read addresses and PE controls are valid this cycle.
REQ-010 SHALL have port rd_addr_a  output  LOGN  upper butterfly operand address.
REQ-011 SHALL have port rd_addr_b  output  LOGN  lower butterfly operand address.
REQ-012 SHALL have port tf_addr  output  LOGN-1  twiddle ROM index.
REQ-013 SHALL have port pe_sub  output  1  PE cell sub control: 0 selects the a-result, 1 selects the b-result.
REQ-014 SHALL have port pe_inv  output  1  PE cell inv control; equals latched inv_mode while busy.
REQ-015 SHALL have port wr_en  output  1  write strobe for the PE result.
REQ-016 SHALL have port wr_addr  output  LOGN  destination address for the PE result.

Function
REQ-017 SHALL latch inv_mode and enter ISSUE when start=1 in IDLE; the first issue occurs the cycle after start.
REQ-018 SHALL ignore start while busy or in DONE.
REQ-019 SHALL iterate stages s=0..LOGN-1 with half-span h=2^s and butterfly index j=0..n/2-1.
REQ-020 SHALL compute addresses as: g=j>>s; k=j&(h-1); rd_addr_a=g*2h+k; rd_addr_b=rd_addr_a+h; tf_addr=k<<(LOGN-1-s).
REQ-021 SHALL issue each butterfly on two consecutive cycles with identical addresses: pe_sub=0 first, then pe_sub=1.
REQ-022 SHALL assert wr_en exactly 2 cycles after each issue cycle (1-cycle RAM read plus 1-cycle PE output register).
REQ-023 SHALL set wr_addr to rd_addr_a for pe_sub=0 issues and to rd_addr_b for pe_sub=1 issues, delayed to match wr_en.
REQ-024 SHALL insert a 2-cycle DRAIN (issue_valid=0) between stages so that every write of stage s lands before the first read of stage s+1.
REQ-025 SHALL use FSM states IDLE, ISSUE, DRAIN, FLUSH and DONE with transitions IDLE->ISSUE (start), ISSUE->DRAIN (end of a non-final stage), DRAIN->ISSUE (after 2 cycles), ISSUE->FLUSH (end of the final stage), FLUSH->DONE (after 2 cycles) and DONE->IDLE (after 1 cycle).
REQ-026 SHALL assert done only in the DONE state; busy=0 in DONE.
REQ-027 SHALL take total latency from start to done of LOGN*n + 2*(LOGN-1) + 3 cycles.
REQ-028 SHALL wrap all counters naturally, with j wrapping to 0 at a stage boundary; no address may exceed n-1.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-transform, force state IDLE, clear counters and the write pipeline, and drive every output to 0 asynchronously.
REQ-030 SHALL produce no write strobe after reset release until a new start.

Configuration
REQ-031 SHALL, when NTT_SCHED_CYCCNT_EN is defined, add output cyc_cnt [15:0]: cleared on start, incremented every busy cycle, held after done, and reset to 0.
REQ-032 SHALL, when NTT_SCHED_CYCCNT_EN is undefined, omit the cyc_cnt port and all of its logic.

Structure
REQ-033 SHALL take the COEFF_W=17 constant, the default LOGN, the FSM state enum and the address typedef from shared package ntt_pkg.
REQ-034 SHALL place the address computation of REQ-020 in combinational sub-module ntt_addr_gen (inputs s and j; outputs the three addresses).

Verification
REQ-035 SHALL verify: LOGN=3, start at cycle 0 -> issue cycles 1-8, 11-18 and 21-28; last wr_en at 30; done=1 only at 31.
REQ-036 SHALL verify: LOGN=3, stage 1, j=3 -> rd_addr_a=5, rd_addr_b=7, tf_addr=2; pe_sub 0 then 1; wr_addr 5 then 7.
REQ-037 SHALL verify: start pulsed again at cycle 5 of a run -> ignored; timing identical to the first scenario.
REQ-038 SHALL verify: rst_n=0 at cycle 15 -> all outputs 0 immediately; no wr_en after release; a new start runs a full sequence.
REQ-039 SHALL verify: inv_mode=1 at start and then dropped to 0 -> pe_inv=1 on every issue cycle; cyc_cnt=30 after done (macro defined).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT butterfly scheduler: coefficient width,
// default transform size, scheduler FSM states and the default address type.
package ntt_pkg;

  localparam int COEFF_W  = 17;
  localparam int LOGN_DEF = 8;

  typedef logic [COEFF_W-1:0]  coeff_t;
  typedef logic [LOGN_DEF-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: maps (stage s, butterfly j) to the
// upper/lower operand addresses and the twiddle ROM index.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN = LOGN_DEF,
  parameter int SW   = 3
) (
  input  logic [SW-1:0]   s_i,
  input  logic [LOGN-2:0] j_i,
  output logic [LOGN-1:0] addr_a_o,
  output logic [LOGN-1:0] addr_b_o,
  output logic [LOGN-2:0] tf_o
);

  logic [LOGN-1:0] jw;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] grp;
  logic [LOGN-1:0] k;
  logic [LOGN-1:0] a;

  always_comb begin
    jw   = {1'b0, j_i};
    half = LOGN'(1) << s_i;
    grp  = jw >> s_i;
    k    = jw & (half - 1'b1);
    // Each group of h butterflies spans 2h points; k is the offset inside the group.
    a    = ((grp << s_i) << 1) + k;
    addr_a_o = a;
    addr_b_o = a + half;
    tf_o     = k[LOGN-2:0] << (LOGN - 1 - int'(s_i));
  end

endmodule

// File: rtl/ntt_butterfly_sched.sv
// In-place radix-2 NTT butterfly scheduler: issues read/PE/write controls for a full
// transform. Optional cycle counter output cyc_cnt is enabled by NTT_SCHED_CYCCNT_EN.
module ntt_butterfly_sched
  import ntt_pkg::*;
#(
  parameter int LOGN = LOGN_DEF,
  parameter int N    = COEFF_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inv_mode,
  output logic            busy,
  output logic            done,
  output logic            issue_valid,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tf_addr,
  output logic            pe_sub,
  output logic            pe_inv,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr
`ifdef NTT_SCHED_CYCCNT_EN
  ,
  output logic [15:0]     cyc_cnt
`endif
);

  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int JW = LOGN - 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  if (N != COEFF_W) begin : g_bad_n
    $error("ntt_butterfly_sched: N must equal ntt_pkg::COEFF_W");
  end

  sched_state_e    state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [JW-1:0]   j_q, j_d;
  logic            sub_q, sub_d;
  logic            wait_q, wait_d;
  logic            inv_q, inv_d;

  logic [LOGN-1:0] gen_a;
  logic [LOGN-1:0] gen_b;
  logic [LOGN-2:0] gen_tf;

  logic            wr_vld_p1_q, wr_vld_p2_q;
  logic [LOGN-1:0] wr_addr_p1_q, wr_addr_p2_q;

  ntt_addr_gen #(
    .LOGN (LOGN),
    .SW   (SW)
  ) u_addr_gen (
    .s_i      (s_q),
    .j_i      (j_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tf_o     (gen_tf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      sub_q   <= 1'b0;
      wait_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      sub_q   <= sub_d;
      wait_q  <= wait_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    sub_d   = sub_q;
    wait_d  = wait_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          inv_d   = inv_mode;
          s_d     = '0;
          j_d     = '0;
          sub_d   = 1'b0;
          wait_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        sub_d = ~sub_q;
        if (sub_q) begin
          // j wraps to 0 on its own at the last butterfly of a stage.
          j_d = j_q + 1'b1;
          if (&j_q) begin
            if (s_q == S_LAST) begin
              s_d     = '0;
              state_d = S_FLUSH;
            end else begin
              s_d     = s_q + 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        wait_d = ~wait_q;
        if (wait_q) state_d = S_ISSUE;
      end
      S_FLUSH: begin
        wait_d = ~wait_q;
        if (wait_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = (state_q == S_ISSUE);
    busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
    done        = (state_q == S_DONE);
    pe_sub      = issue_valid & sub_q;
    pe_inv      = busy & inv_q;
    rd_addr_a   = issue_valid ? gen_a  : '0;
    rd_addr_b   = issue_valid ? gen_b  : '0;
    tf_addr     = issue_valid ? gen_tf : '0;
    wr_en       = wr_vld_p2_q;
    wr_addr     = wr_addr_p2_q;
  end

  // p1: RAM read in flight; p2: PE output register, result written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1_q  <= 1'b0;
      wr_vld_p2_q  <= 1'b0;
      wr_addr_p1_q <= '0;
      wr_addr_p2_q <= '0;
    end else begin
      wr_vld_p1_q  <= issue_valid;
      wr_vld_p2_q  <= wr_vld_p1_q;
      wr_addr_p1_q <= pe_sub ? rd_addr_b : rd_addr_a;
      wr_addr_p2_q <= wr_addr_p1_q;
    end
  end

`ifdef NTT_SCHED_CYCCNT_EN
  logic [15:0] cyc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      cyc_cnt_q <= '0;
    end else if (busy) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_butterfly_sched.sv
// Randomized self-checking bench for ntt_butterfly_sched (LOGN=3) against a
// per-cycle schedule built from the transform's loop structure.
module tb_ntt_butterfly_sched;

  localparam int LOGN  = 3;
  localparam int NPTS  = 1 << LOGN;
  localparam int TOTAL = LOGN * NPTS + 2 * (LOGN - 1) + 3;
  localparam int DEPTH = TOTAL + 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            inv_mode = 1'b0;
  logic            busy, done, issue_valid, pe_sub, pe_inv, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [LOGN-2:0] tf_addr;
`ifdef NTT_SCHED_CYCCNT_EN
  logic [15:0]     cyc_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int e_iss [DEPTH];
  int e_a   [DEPTH];
  int e_b   [DEPTH];
  int e_tf  [DEPTH];
  int e_sub [DEPTH];
  int e_wr  [DEPTH];
  int e_wa  [DEPTH];
  int e_busy[DEPTH];
  int e_done[DEPTH];

  ntt_butterfly_sched #(
    .LOGN (LOGN),
    .N    (17)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inv_mode    (inv_mode),
    .busy        (busy),
    .done        (done),
    .issue_valid (issue_valid),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tf_addr     (tf_addr),
    .pe_sub      (pe_sub),
    .pe_inv      (pe_inv),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr)
`ifdef NTT_SCHED_CYCCNT_EN
    ,
    .cyc_cnt     (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected schedule for a start at cycle 0: stage loop, butterfly loop, two issues each.
  function automatic void build_model();
    int t, h, a, k;
    for (int i = 0; i < DEPTH; i++) begin
      e_iss[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tf[i] = 0; e_sub[i] = 0;
      e_wr[i] = 0; e_wa[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    end
    t = 1;
    for (int s = 0; s < LOGN; s++) begin
      h = 1 << s;
      for (int j = 0; j < NPTS / 2; j++) begin
        k = j % h;
        a = (j / h) * 2 * h + k;
        for (int sub = 0; sub < 2; sub++) begin
          e_iss[t] = 1;
          e_a[t]   = a;
          e_b[t]   = a + h;
          e_tf[t]  = k * (NPTS / 2) / h;
          e_sub[t] = sub;
          e_wr[t + 2] = 1;
          e_wa[t + 2] = (sub == 1) ? a + h : a;
          t++;
        end
      end
      if (s != LOGN - 1) t += 2;
    end
    for (int i = 1; i < t + 2; i++) e_busy[i] = 1;
    e_done[t + 2] = 1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_iss"},  issue_valid, 0);
    check_eq({tag, "_a"},    rd_addr_a, 0);
    check_eq({tag, "_b"},    rd_addr_b, 0);
    check_eq({tag, "_tf"},   tf_addr, 0);
    check_eq({tag, "_sub"},  pe_sub, 0);
    check_eq({tag, "_inv"},  pe_inv, 0);
    check_eq({tag, "_wr"},   wr_en, 0);
    check_eq({tag, "_wa"},   wr_addr, 0);
`ifdef NTT_SCHED_CYCCNT_EN
    check_eq({tag, "_cnt"},  cyc_cnt, 0);
`endif
  endtask

  task automatic check_cycle(input int t, input bit inv);
    check_eq($sformatf("iss@%0d", t),  issue_valid, e_iss[t]);
    check_eq($sformatf("busy@%0d", t), busy, e_busy[t]);
    check_eq($sformatf("done@%0d", t), done, e_done[t]);
    check_eq($sformatf("wr@%0d", t),   wr_en, e_wr[t]);
    if (e_iss[t] != 0) begin
      check_eq($sformatf("a@%0d", t),   rd_addr_a, e_a[t]);
      check_eq($sformatf("b@%0d", t),   rd_addr_b, e_b[t]);
      check_eq($sformatf("tf@%0d", t),  tf_addr, e_tf[t]);
      check_eq($sformatf("sub@%0d", t), pe_sub, e_sub[t]);
    end
    if (e_busy[t] != 0) check_eq($sformatf("inv@%0d", t), pe_inv, inv);
    if (e_wr[t] != 0)   check_eq($sformatf("wa@%0d", t), wr_addr, e_wa[t]);
    if (t == 17) begin
      check_eq("s1j3_a", rd_addr_a, 5);
      check_eq("s1j3_b", rd_addr_b, 7);
      check_eq("s1j3_tf", tf_addr, 2);
    end
    if (t == 19) check_eq("s1j3_wa0", wr_addr, 5);
    if (t == 20) check_eq("s1j3_wa1", wr_addr, 7);
`ifdef NTT_SCHED_CYCCNT_EN
    if (t >= 1) check_eq($sformatf("cnt@%0d", t), cyc_cnt, (t - 1 < TOTAL - 1) ? t - 1 : TOTAL - 1);
`endif
  endtask

  // Start at relative cycle 0; optional spurious start at spur_at, optional reset at rst_at.
  task automatic run_seq(input bit inv, input int spur_at, input int rst_at);
    @(posedge clk); #1;
    start    = 1'b1;
    inv_mode = inv;
    for (int t = 0; t <= TOTAL + 1; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        start = (t == spur_at);
        if (t == 1) inv_mode = 1'($urandom_range(0, 1));
        if (t == rst_at) begin
          start = 1'b0;
          rst_n = 1'b0;
          #1;
          check_all_zero($sformatf("rst@%0d", t));
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          for (int c = 0; c < 2 * NPTS; c++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_wr@%0d", c),  wr_en, 0);
            check_eq($sformatf("post_rst_iss@%0d", c), issue_valid, 0);
            check_eq($sformatf("post_rst_busy@%0d", c), busy, 0);
          end
          return;
        end
      end
      @(negedge clk);
      check_cycle(t, inv);
    end
  endtask

  task automatic idle_gap(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      inv_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("gap_iss", issue_valid, 0);
      check_eq("gap_wr", wr_en, 0);
      check_eq("gap_done", done, 0);
      check_eq("gap_busy", busy, 0);
`ifdef NTT_SCHED_CYCCNT_EN
      check_eq("gap_cnt_hold", cyc_cnt, TOTAL - 1);
`endif
    end
  endtask

  initial begin
    int spur, rst_at;
    bit inv;
    build_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_iss", issue_valid, 0);
    check_eq("idle_busy", busy, 0);

    run_seq(1'b0, -1, -1);
    idle_gap(2);
    run_seq(1'b1, -1, -1);
    idle_gap(1);
    run_seq(1'b0, 5, -1);
    run_seq(1'b0, TOTAL, -1);
    run_seq(1'b1, -1, 15);
    run_seq(1'b0, -1, -1);

    for (int it = 0; it < 8; it++) begin
      idle_gap($urandom_range(0, 3));
      inv    = 1'($urandom_range(0, 1));
      spur   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, TOTAL)) : -1;
      rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TOTAL + 1)) : -1;
      if (rst_at == spur) spur = -1;
      run_seq(inv, spur, rst_at);
      if (rst_at >= 0) run_seq(inv, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
